// File: rtl/button_input_if.sv
// Avalon-MM bus bundle between the CPU (master) and the button input port (slave).
// No waitrequest and a fixed read latency of 1: every edge with slave_read or slave_write high is accepted.
interface button_input_if;
  logic [3:0] slave_address;
  logic       slave_read;
  logic       slave_write;
  logic [7:0] slave_readdata;
  logic [7:0] slave_writedata;
  logic       slave_byteenable;

  modport master (
    output slave_address,
    output slave_read,
    output slave_write,
    output slave_writedata,
    output slave_byteenable,
    input  slave_readdata
  );

  modport slave (
    input  slave_address,
    input  slave_read,
    input  slave_write,
    input  slave_writedata,
    input  slave_byteenable,
    output slave_readdata
  );
endinterface

// File: rtl/button_input.sv
// Push-button input port: 2-flop sync, per-bit debounce, rising-edge latch with W1C,
// maskable level interrupt and an Avalon-MM register slave (DATA/EDGE/MASK/RAW).
module button_input #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  button_input_if.slave    bus,
  input  logic [WIDTH-1:0] user_datain_0,
  output logic             irq
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] ADDR_DATA = 4'h0;
  localparam logic [3:0] ADDR_EDGE = 4'h1;
  localparam logic [3:0] ADDR_MASK = 4'h2;
  localparam logic [3:0] ADDR_RAW  = 4'h3;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] edge_q,  edge_d;
  logic [WIDTH-1:0] mask_q,  mask_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [7:0]       rdata_q, rdata_d;
  logic             irq_q,   irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] w1c;

  assign wr_en = bus.slave_write & bus.slave_byteenable;

  // A bit is accepted only after it has disagreed with the held state for
  // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          state_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = state_d & ~state_q;

  always_comb begin
    w1c = '0;
    if (wr_en && (bus.slave_address == ADDR_EDGE)) begin
      w1c = bus.slave_writedata[WIDTH-1:0];
    end
  end

  // A new press on the same edge as its clear must not be lost.
  assign edge_d = (edge_q & ~w1c) | rise;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && (bus.slave_address == ADDR_MASK)) begin
      mask_d = bus.slave_writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (bus.slave_read) begin
      case (bus.slave_address)
        ADDR_DATA: rdata_d = 8'(state_q);
        ADDR_EDGE: rdata_d = 8'(edge_q);
        ADDR_MASK: rdata_d = 8'(mask_q);
        ADDR_RAW:  rdata_d = 8'(sync2_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  assign irq_d = |(edge_q & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= user_datain_0;
      sync2_q <= sync1_q;
      state_q <= state_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.slave_readdata = rdata_q;
  assign irq                = irq_q;

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with WIDTH=8, DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_button_input;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] pins;
  logic             irq;

  int n_cmp = 0;
  int n_err = 0;

  button_input_if bus ();

  button_input #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus.slave),
    .user_datain_0 (pins),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [7:0] data, input logic be);
    @(negedge clk);
    bus.slave_address    = addr;
    bus.slave_writedata  = data;
    bus.slave_byteenable = be;
    bus.slave_write      = 1'b1;
    @(negedge clk);
    bus.slave_write      = 1'b0;
    bus.slave_byteenable = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [7:0] rd);
    @(negedge clk);
    bus.slave_address = addr;
    bus.slave_read    = 1'b1;
    @(negedge clk);
    rd                = bus.slave_readdata;
    bus.slave_read    = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] rd;
    logic [7:0] exp;
    @(negedge clk);
    pins = 8'hFF;
    wait_clks(10);
    bus_write(4'h2, 8'hFF, 1'b1);
    wait_clks(2);
    @(negedge clk);
    bus.slave_address = 4'h0;
    bus.slave_read    = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.slave_readdata !== 8'hFF) begin
      n_err++; $display("FAIL reset_pre_data: got %h expected %h", bus.slave_readdata, 8'hFF);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_irq: got %b expected %b", irq, 1'b1);
    end
    pins = 8'h00;
    wait_clks(3);
    #2;
    reset_n = 1'b0;
    pins    = 8'hFF;
    #1;
    n_cmp++;
    if (bus.slave_readdata !== 8'h00) begin
      n_err++; $display("FAIL reset_async_rdata: got %h expected %h", bus.slave_readdata, 8'h00);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL reset_async_irq: got %b expected %b", irq, 1'b0);
    end
    wait_clks(2);
    reset_n = 1'b1;
    // State updates on edge 6 after release; registered read shows it one edge later.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = (k >= 7) ? 8'hFF : 8'h00;
      n_cmp++;
      if (bus.slave_readdata !== exp) begin
        n_err++; $display("FAIL reset_latency k=%0d: got %h expected %h", k, bus.slave_readdata, exp);
      end
    end
    bus.slave_read = 1'b0;
    bus_read(4'h2, rd);
    n_cmp++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL reset_mask: got %h expected %h", rd, 8'h00);
    end
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'hFF) begin
      n_err++; $display("FAIL reset_edge_after: got %h expected %h", rd, 8'hFF);
    end
    bus_read(4'h3, rd);
    n_cmp++;
    if (rd !== 8'hFF) begin
      n_err++; $display("FAIL reset_raw: got %h expected %h", rd, 8'hFF);
    end
  endtask

  task automatic test_debounce();
    logic [7:0] rd;
    logic [7:0] exp;
    @(negedge clk);
    pins = 8'h00;
    wait_clks(10);
    bus_write(4'h1, 8'hFF, 1'b1);
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL deb_edge_cleared: got %h expected %h", rd, 8'h00);
    end
    @(negedge clk);
    pins              = 8'h01;
    bus.slave_address = 4'h0;
    bus.slave_read    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = (k >= 7) ? 8'h01 : 8'h00;
      n_cmp++;
      if (bus.slave_readdata !== exp) begin
        n_err++; $display("FAIL deb_rise k=%0d: got %h expected %h", k, bus.slave_readdata, exp);
      end
    end
    bus.slave_read = 1'b0;
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h01) begin
      n_err++; $display("FAIL deb_edge_set: got %h expected %h", rd, 8'h01);
    end
    // Bit1 high for exactly three sampling edges: visible on RAW, rejected by debounce.
    @(negedge clk);
    pins              = 8'h03;
    bus.slave_address = 4'h3;
    bus.slave_read    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = (k >= 3 && k <= 5) ? 8'h03 : 8'h01;
      n_cmp++;
      if (bus.slave_readdata !== exp) begin
        n_err++; $display("FAIL deb_glitch_raw k=%0d: got %h expected %h", k, bus.slave_readdata, exp);
      end
      if (k == 3) pins = 8'h01;
    end
    bus.slave_read = 1'b0;
    wait_clks(4);
    bus_read(4'h0, rd);
    n_cmp++;
    if (rd !== 8'h01) begin
      n_err++; $display("FAIL deb_glitch_data: got %h expected %h", rd, 8'h01);
    end
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h01) begin
      n_err++; $display("FAIL deb_glitch_edge: got %h expected %h", rd, 8'h01);
    end
  endtask

  task automatic test_w1c();
    logic [7:0] rd;
    @(negedge clk);
    pins = 8'h05;
    wait_clks(10);
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h05) begin
      n_err++; $display("FAIL w1c_init: got %h expected %h", rd, 8'h05);
    end
    bus_write(4'h1, 8'h01, 1'b1);
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h04) begin
      n_err++; $display("FAIL w1c_clear_bit0: got %h expected %h", rd, 8'h04);
    end
    bus_write(4'h1, 8'h00, 1'b1);
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h04) begin
      n_err++; $display("FAIL w1c_write_zero: got %h expected %h", rd, 8'h04);
    end
    @(negedge clk);
    pins = 8'h04;
    wait_clks(10);
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h04) begin
      n_err++; $display("FAIL w1c_fall_no_edge: got %h expected %h", rd, 8'h04);
    end
    bus_read(4'h0, rd);
    n_cmp++;
    if (rd !== 8'h04) begin
      n_err++; $display("FAIL w1c_fall_data: got %h expected %h", rd, 8'h04);
    end
    // Land the bit0 clear on edge 6, the edge where bit0 state rises.
    @(negedge clk);
    pins = 8'h05;
    repeat (5) @(negedge clk);
    bus.slave_address    = 4'h1;
    bus.slave_writedata  = 8'h01;
    bus.slave_byteenable = 1'b1;
    bus.slave_write      = 1'b1;
    @(negedge clk);
    bus.slave_write      = 1'b0;
    bus.slave_byteenable = 1'b0;
    bus_read(4'h0, rd);
    n_cmp++;
    if (rd !== 8'h05) begin
      n_err++; $display("FAIL w1c_same_edge_data: got %h expected %h", rd, 8'h05);
    end
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h05) begin
      n_err++; $display("FAIL w1c_set_wins: got %h expected %h", rd, 8'h05);
    end
  endtask

  task automatic test_irq();
    logic [7:0] rd;
    bus_write(4'h1, 8'hFF, 1'b1);
    bus_write(4'h2, 8'h04, 1'b1);
    wait_clks(2);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL irq_idle: got %b expected %b", irq, 1'b0);
    end
    @(negedge clk);
    pins = 8'h01;
    wait_clks(10);
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL irq_edge_empty: got %h expected %h", rd, 8'h00);
    end
    @(negedge clk);
    pins = 8'h05;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL irq_same_edge: got %b expected %b", irq, 1'b0);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL irq_next_clock: got %b expected %b", irq, 1'b1);
    end
    bus_write(4'h1, 8'h04, 1'b1);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL irq_clear_lag: got %b expected %b", irq, 1'b1);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL irq_cleared: got %b expected %b", irq, 1'b0);
    end
    @(negedge clk);
    pins = 8'h04;
    wait_clks(10);
    pins = 8'h05;
    wait_clks(10);
    bus_read(4'h1, rd);
    n_cmp++;
    if (rd !== 8'h01) begin
      n_err++; $display("FAIL irq_unmasked_edge: got %h expected %h", rd, 8'h01);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL irq_masked_off: got %b expected %b", irq, 1'b0);
    end
  endtask

  task automatic test_bus();
    logic [7:0] rd;
    bus_read(4'h7, rd);
    n_cmp++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL bus_unmapped7: got %h expected %h", rd, 8'h00);
    end
    bus_read(4'h4, rd);
    n_cmp++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL bus_unmapped4: got %h expected %h", rd, 8'h00);
    end
    bus_write(4'h2, 8'hAA, 1'b0);
    bus_read(4'h2, rd);
    n_cmp++;
    if (rd !== 8'h04) begin
      n_err++; $display("FAIL bus_be0_ignored: got %h expected %h", rd, 8'h04);
    end
    @(negedge clk);
    bus.slave_address = 4'h2;
    bus.slave_read    = 1'b1;
    n_cmp++;
    if (bus.slave_readdata !== 8'h00) begin
      n_err++; $display("FAIL bus_rd_before: got %h expected %h", bus.slave_readdata, 8'h00);
    end
    @(negedge clk);
    bus.slave_read = 1'b0;
    n_cmp++;
    if (bus.slave_readdata !== 8'h04) begin
      n_err++; $display("FAIL bus_rd_latency1: got %h expected %h", bus.slave_readdata, 8'h04);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.slave_readdata !== 8'h00) begin
      n_err++; $display("FAIL bus_rd_after: got %h expected %h", bus.slave_readdata, 8'h00);
    end
    @(negedge clk);
    bus.slave_address    = 4'h2;
    bus.slave_writedata  = 8'h11;
    bus.slave_byteenable = 1'b1;
    bus.slave_write      = 1'b1;
    bus.slave_read       = 1'b1;
    @(negedge clk);
    bus.slave_write      = 1'b0;
    bus.slave_byteenable = 1'b0;
    bus.slave_read       = 1'b0;
    n_cmp++;
    if (bus.slave_readdata !== 8'h04) begin
      n_err++; $display("FAIL bus_rw_prewrite: got %h expected %h", bus.slave_readdata, 8'h04);
    end
    bus_read(4'h2, rd);
    n_cmp++;
    if (rd !== 8'h11) begin
      n_err++; $display("FAIL bus_mask_written: got %h expected %h", rd, 8'h11);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL bus_irq_mask_bit0: got %b expected %b", irq, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.slave_address = 4'h0;
    bus.slave_read    = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.slave_readdata !== 8'h05) begin
      n_err++; $display("FAIL b2b_data: got %h expected %h", bus.slave_readdata, 8'h05);
    end
    bus.slave_address = 4'h2;
    @(negedge clk);
    n_cmp++;
    if (bus.slave_readdata !== 8'h11) begin
      n_err++; $display("FAIL b2b_mask: got %h expected %h", bus.slave_readdata, 8'h11);
    end
    bus.slave_address = 4'h3;
    @(negedge clk);
    n_cmp++;
    if (bus.slave_readdata !== 8'h05) begin
      n_err++; $display("FAIL b2b_raw: got %h expected %h", bus.slave_readdata, 8'h05);
    end
    bus.slave_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.slave_readdata !== 8'h00) begin
      n_err++; $display("FAIL b2b_idle: got %h expected %h", bus.slave_readdata, 8'h00);
    end
  endtask

  // ---------------- clock/reset and sequence ----------------
  initial begin
    reset_n              = 1'b0;
    pins                 = '0;
    bus.slave_address    = '0;
    bus.slave_read       = 1'b0;
    bus.slave_write      = 1'b0;
    bus.slave_writedata  = '0;
    bus.slave_byteenable = 1'b0;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(2);

    test_reset();
    test_debounce();
    test_w1c();
    test_irq();
    test_bus();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
